// File: rtl/cell_button_conditioner.sv
// Purpose: turns nine raw bouncy cell buttons into clean one-hot cell-press pulses for the game core.
// Latency: a clean press reaches cell_press DEBOUNCE_CYCLES+3 cycles after it is first sampled.
// Backpressure: none; lock discards new presses, and busy stays high until every button is released.
module cell_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PULSE_CYCLES    = 4,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] btn_raw,
    input  logic       lock,
    output logic [8:0] cell_press,
    output logic       busy,
    output logic       collision,
    output logic [8:0] btn_level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PLS_W = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PLS_W-1:0] PULSE_LAST = PLS_W'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_RELEASE_WAIT
    } state_t;

    logic [8:0]       btn_act;
    logic [8:0]       sync_q1;
    logic [8:0]       sync_q2;
    logic [CNT_W-1:0] db_cnt [9];
    logic [8:0]       btn_level_d;
    logic [8:0]       press_edge;
    logic             edge_one_hot;
    logic             edge_multi;

    state_t           state;
    state_t           state_nx;
    logic [8:0]       press_nx;
    logic [PLS_W-1:0] pulse_cnt;
    logic [PLS_W-1:0] pulse_cnt_nx;
    logic             collision_nx;

    // Polarity is normalised before the synchroniser so everything after it is "1 = pressed".
    assign btn_act = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn_act;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_level <= '0;
            for (int k = 0; k < 9; k++) begin
                db_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 9; k++) begin
                if (sync_q2[k] != btn_level[k]) begin
                    if (db_cnt[k] == DB_LAST) begin
                        btn_level[k] <= ~btn_level[k];
                        db_cnt[k]    <= '0;
                    end else begin
                        db_cnt[k] <= db_cnt[k] + 1'b1;
                    end
                end else begin
                    db_cnt[k] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_level_d <= '0;
            press_edge  <= '0;
        end else begin
            btn_level_d <= btn_level;
            press_edge  <= btn_level & ~btn_level_d;
        end
    end

    assign edge_one_hot = (press_edge != '0) && ((press_edge & (press_edge - 9'd1)) == '0);
    assign edge_multi   = (press_edge != '0) && !edge_one_hot;

    always_comb begin
        state_nx     = state;
        press_nx     = cell_press;
        pulse_cnt_nx = pulse_cnt;
        collision_nx = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!lock && edge_one_hot) begin
                    press_nx     = press_edge;
                    pulse_cnt_nx = '0;
                    state_nx     = S_PULSE;
                end else if (!lock && edge_multi) begin
                    collision_nx = 1'b1;
                    state_nx     = S_RELEASE_WAIT;
                end
            end
            S_PULSE: begin
                // lock is deliberately not looked at here: an accepted move always completes.
                if (pulse_cnt == PULSE_LAST) begin
                    press_nx = '0;
                    state_nx = S_RELEASE_WAIT;
                end else begin
                    pulse_cnt_nx = pulse_cnt + 1'b1;
                end
            end
            S_RELEASE_WAIT: begin
                if (btn_level == '0) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                press_nx = '0;
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cell_press <= '0;
            pulse_cnt  <= '0;
            busy       <= 1'b0;
            collision  <= 1'b0;
        end else begin
            state      <= state_nx;
            cell_press <= press_nx;
            pulse_cnt  <= pulse_cnt_nx;
            busy       <= (state_nx != S_IDLE);
            collision  <= collision_nx;
        end
    end

endmodule

// File: doc/cell_button_conditioner.md
Name: cell_button_conditioner

Overview:
Input stage directly upstream of the tic_tac_toe top. Takes nine raw, bouncy, asynchronous cell push-buttons (a..i) and converts them into clean, synchronised cell-press levels that drive a_button..i_button. Each accepted press produces exactly one fixed-length assertion on one cell line. Multi-button presses, bounce, held buttons and locked periods (AI turn) never produce spurious moves.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed before a debounced level changes; counter width is $clog2(DEBOUNCE_CYCLES+1).
PULSE_CYCLES, 4, number of cycles an accepted press is held on cell_press; must be at least 1.
BTN_ACTIVE_LOW, 1, 1 means btn_raw bit = 0 when pressed; 0 means active-high.

Ports:
clk  input  1  system clock; the only clock.
reset  input  1  synchronous, active-high reset; same signal as the game reset.
btn_raw  input  9  raw cell buttons, bit0=a ... bit8=i, asynchronous.
lock  input  1  high = ignore new presses (driven from ai_turn or game-over).
cell_press  output  9  one-hot or zero; active-high; bit0=a ... bit8=i; feeds a_button..i_button.
busy  output  1  high while in PULSE or RELEASE_WAIT.
collision  output  1  one-cycle pulse when a multi-button press is rejected.
btn_level  output  9  debounced pressed levels, active-high, for debug/LEDs.

Behaviour:
- Reset is synchronous, and everything is evaluated on posedge clk with reset taking priority. On reset: synchroniser FFs load the "released" level; debounce counters = 0; btn_level = 0; edge register = 0; FSM = IDLE; cell_press = 0; busy = 0; collision = 0. Reset mid-PULSE truncates the pulse immediately, at the next edge.
- Polarity: raw input is inverted when BTN_ACTIVE_LOW=1, before the synchroniser, so all internal logic is active-high pressed.
- Synchroniser: 2-FF per bit; no logic between the two flops.
- Debounce, per bit and independent:
  - If sync output != btn_level, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the mismatch persists, btn_level toggles and the counter clears.
  - Any cycle with sync == btn_level clears the counter.
  - The counter never wraps.
- Edge detect: press_edge[k] = btn_level[k] & ~btn_level_d[k], registered one cycle.
- Latency: a raw press held clean produces cell_press high exactly DEBOUNCE_CYCLES+3 cycles after the first clock edge that samples it.
- FSM states: IDLE, PULSE, RELEASE_WAIT.
  - IDLE, lock=1: all edges are discarded; no collision; remain IDLE.
  - IDLE, lock=0, exactly one edge bit set: load that one-hot into the cell_press register, clear the pulse counter, go to PULSE. cell_press is asserted starting the next cycle.
  - IDLE, lock=0, two or more edge bits in the same cycle: collision=1 for one cycle, cell_press stays 0, go to RELEASE_WAIT.
  - PULSE: cell_press is held constant for exactly PULSE_CYCLES cycles, then cleared; go to RELEASE_WAIT.
    - Edges arriving during PULSE are ignored.
    - lock rising during PULSE does not shorten the pulse.
  - RELEASE_WAIT: stay until btn_level == 0 (all buttons released), then go to IDLE on the next edge. Edges here are ignored.
  - busy = (state != IDLE), registered with the state.
- Invariants:
  - cell_press is never multi-hot.
  - A continuously held button generates exactly one pulse.
  - A second button pressed while the first is still held generates nothing.
- A press whose edge coincides with lock=1 is lost permanently. The user must release and press again.

Test Plan:
1. DEBOUNCE_CYCLES=4, PULSE_CYCLES=2, active-low. Reset, then btn_raw=9'h1FE held clean -> cell_press=9'h001 for exactly 2 cycles, first high 7 cycles after the press sample; busy high until release; after release, busy low and cell_press=0.
2. Bounce: toggle bit4 every 2 cycles for 12 cycles, then hold pressed -> no cell_press during bouncing; a single 9'h010 pulse appears 7 cycles after the last toggle.
3. Simultaneous press of bits 0 and 8 in the same cycle -> collision=1 for one cycle, cell_press stays 0, busy=1 until both are released.
4. Hold bit2, and while held press bit5 -> exactly one 9'h004 pulse, no pulse for bit5; release both, then press bit5 -> 9'h020 pulse.
5. lock=1 during the bit3 press edge, then lock=0 while still held -> no pulse; release and re-press with lock=0 -> 9'h008 pulse.
6. Assert reset during the second PULSE cycle -> cell_press=0 and busy=0 the next cycle; FSM is IDLE and btn_level=0 even though the button is still held.
